// File: rtl/dmem_pkg.sv
// Shared types and constants for the LEGv8 responder-side data memory.
// Address checking lives here so every user agrees on what an erroneous access is.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int SLOT_SHIFT = 3;
    localparam int WAIT_W     = 4;

    // Misaligned doubleword, or slot beyond the array; full 32-bit compare so high addresses never alias.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        return (addr[SLOT_SHIFT-1:0] != '0) || ((addr >> SLOT_SHIFT) >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with synchronous write and registered read.
// Read-during-write on the same slot returns the old contents.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: accepts LDUR/STUR requests, waits WAIT cycles,
// then presents read data or a store acknowledge on a valid/ready response channel.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   cnt_reg, cnt_next;
    logic [AW-1:0]       slot_reg;
    logic [31:0]         wdata_reg;
    logic                we_reg;
    logic                err_reg;

    logic                accept;
    logic                req_err;
    logic                enter_resp;
    logic                eff_we;
    logic                eff_err;
    logic [AW-1:0]       arr_addr;
    logic [31:0]         arr_wdata;
    logic                arr_we;
    logic [31:0]         arr_rdata;

    assign accept  = (state_reg == ST_IDLE) && req_valid;
    assign req_err = addr_err(req_addr, DEPTH);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_next   = WAIT_W'(WAIT);
                    state_next = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_next = (cnt_reg != '0) ? cnt_reg - WAIT_W'(1) : '0;
                if (cnt_reg <= WAIT_W'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            slot_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                slot_reg  <= req_addr[SLOT_SHIFT +: AW];
                wdata_reg <= req_wdata;
                we_reg    <= req_we;
                err_reg   <= req_err;
            end
        end
    end

    // With WAIT=0 the commit/read edge is the acceptance edge, so the array sees the live request.
    assign enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);
    assign eff_we     = (state_reg == ST_IDLE) ? req_we    : we_reg;
    assign eff_err    = (state_reg == ST_IDLE) ? req_err   : err_reg;
    assign arr_addr   = (state_reg == ST_IDLE) ? req_addr[SLOT_SHIFT +: AW] : slot_reg;
    assign arr_wdata  = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;
    assign arr_we     = enter_resp && eff_we && !eff_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign req_ready = (state_reg == ST_IDLE) && !rst;
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_rdata = (rsp_valid && !we_reg && !err_reg) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT=2 and WAIT=0) exercised in turn
// against an array-based memory model, directed cases plus randomized traffic.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    int          sel;

    logic        req_ready0, rsp_valid0, rsp_err0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata0, rsp_rdata1;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT(W0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 0), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready && sel == 0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT(W1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 1), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready && sel == 1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    assign req_ready_m = (sel == 0) ? req_ready0 : req_ready1;
    assign rsp_valid_m = (sel == 0) ? rsp_valid0 : rsp_valid1;
    assign rsp_err_m   = (sel == 0) ? rsp_err0   : rsp_err1;
    assign rsp_rdata_m = (sel == 0) ? rsp_rdata0 : rsp_rdata1;

    function automatic int exp_lat();
        return ((sel == 0) ? W0 : W1) + 1;
    endfunction

    // Reference: doubleword slots, only aligned in-range accesses touch memory.
    task automatic model_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] exp_d, output logic exp_e);
        exp_e = (a % 8 != 0) || (a / 8 >= DEPTH);
        exp_d = (we || exp_e) ? 32'h0 : mdl[sel][a / 8];
        if (we && !exp_e) mdl[sel][a / 8] = wd;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        lat = -1;
        rd  = 32'hxxxx_xxxx;
        er  = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (rsp_valid_m) begin
                lat = k;
                break;
            end
        end
        if (lat > 0) begin
            rd = rsp_rdata_m;
            er = rsp_err_m;
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
        $display("txn sel=%0d we=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d", sel, we, a, wd, rd, er, lat);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready0 !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_rdata0 !== 32'h0 || rsp_err0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
                     req_ready0, rsp_valid0, rsp_rdata0, rsp_err0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready0=%b ready1=%b valid0=%b valid1=%b required 1 1 0 0",
                     req_ready0, req_ready1, rsp_valid0, rsp_valid1);
        end
    endtask

    task automatic test_fill();
        logic [31:0] ed, rd, wd;
        logic ee, er;
        int lat;
        for (int s = 0; s < DEPTH; s++) begin
            wd = $urandom;
            model_txn(1'b1, 32'(s * 8), wd, ed, ee);
            do_txn(1'b1, 32'(s * 8), wd, 0, rd, er, lat);
        end
    endtask

    // Directed list: basic store/load, vector pair, misaligned, out-of-range, non-wrapping high address.
    task automatic test_directed();
        logic        we_l [10] = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
        logic [31:0] a_l  [10] = '{32'h10, 32'h10, 32'h00, 32'h08, 32'h00, 32'h08, 32'h0C, 32'h08, 32'h200, 32'h8000_0010};
        logic [31:0] d_l  [10] = '{32'h1234, 32'h2A, 32'h7, 32'h3, 0, 0, 32'h99, 0, 0, 0};
        logic [31:0] ed, rd;
        logic ee, er;
        int lat;
        for (int i = 0; i < 10; i++) begin
            model_txn(we_l[i], a_l[i], d_l[i], ed, ee);
            do_txn(we_l[i], a_l[i], d_l[i], i % 3, rd, er, lat);
            checks++;
            if (lat !== exp_lat() || rd !== ed || er !== ee) begin
                failures++;
                $display("FAIL directed[%0d] sel=%0d addr=%h: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                         i, sel, a_l[i], lat, rd, er, exp_lat(), ed, ee);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed, rd;
        logic ee, er;
        int lat;
        model_txn(1'b0, 32'h10, 32'h0, ed, ee);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        // Keep a store presented while busy; it must be ignored.
        #1 req_we = 1'b1; req_addr = 32'h28; req_wdata = 32'hDEAD_BEEF;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (rsp_valid_m) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== exp_lat()) begin
            failures++;
            $display("FAIL bp_latency sel=%0d: lat=%0d required %0d", sel, lat, exp_lat());
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== ed || rsp_err_m !== 1'b0 || req_ready_m !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] sel=%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h 0 0",
                         c, sel, rsp_valid_m, rsp_rdata_m, rsp_err_m, req_ready_m, ed);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
        checks++;
        if (rsp_valid_m !== 1'b0 || req_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL bp_release sel=%0d: valid=%b ready=%b required 0 1", sel, rsp_valid_m, req_ready_m);
        end
        model_txn(1'b0, 32'h28, 32'h0, ed, ee);
        do_txn(1'b0, 32'h28, 32'h0, 0, rd, er, lat);
        checks++;
        if (rd !== ed || er !== ee) begin
            failures++;
            $display("FAIL bp_ignored_store sel=%0d: rdata=%h err=%b required %h %b", sel, rd, er, ed, ee);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ed, rd;
        logic ee, er;
        int lat;
        int seen;
        model_txn(1'b1, 32'h18, 32'h11, ed, ee);
        do_txn(1'b1, 32'h18, 32'h11, 0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid_m !== 1'b0 || req_ready_m !== 1'b0 || rsp_rdata_m !== 32'h0 || rsp_err_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: valid=%b ready=%b rdata=%h err=%b required 0 0 0 0",
                     rsp_valid_m, req_ready_m, rsp_rdata_m, rsp_err_m);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid_m) seen++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_m) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_no_rsp: responses=%0d required 0", seen);
        end
        model_txn(1'b0, 32'h18, 32'h0, ed, ee);
        do_txn(1'b0, 32'h18, 32'h0, 0, rd, er, lat);
        checks++;
        if (rd !== ed || er !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_commit: rdata=%h err=%b required %h 0", rd, er, ed);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, wd, ed, rd;
        logic we, ee, er;
        int kind, lat;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 8 + $urandom_range(1, 7));
            else if (kind == 1) a = 32'(DEPTH * 8) + ($urandom & 32'h7FFF_FFF8);
            else                a = 32'($urandom_range(0, DEPTH - 1) * 8);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            model_txn(we, a, wd, ed, ee);
            do_txn(we, a, wd, $urandom_range(0, 3), rd, er, lat);
            checks++;
            if (lat !== exp_lat() || rd !== ed || er !== ee) begin
                failures++;
                $display("FAIL random[%0d] sel=%0d we=%b addr=%h: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                         i, sel, we, a, lat, rd, er, exp_lat(), ed, ee);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        sel = 0;
        test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            test_fill();
            test_directed();
            test_backpressure();
            if (s == 0) test_reset_mid();
            test_random(40);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
